slave_fifo2b_stream_in: RTL and testbench
=========================================

Name: slave_fifo2b_stream_in

Overview:
FPGA-side write master for the FX3 Slave FIFO (2-bit address) interface in Stream IN mode. It moves data from the FPGA to the FX3 (USB IN direction), the counterpart of the Stream OUT reader. It watches the registered FX3 DMA flags (FLAGA = socket ready, FLAGB = watermark/partial-full) and drives SLWR# while presenting an incrementing 32-bit test pattern on the GPIF data bus. It sits beside the Stream OUT block; the top level muxes the two blocks' strobes and data by mode.

Parameters:
DATA_INIT, 32'd0, value of the data pattern after reset.
WR_DELAY, 2, idle cycles after the last write before FLAGA is sampled again (covers FX3 flag latency); legal range 0..7.
PKT_BEATS, 512, beats per committed short packet; used only with the optional feature; legal range 1..65535.

Ports:
clk_100  input  1  interface clock, 100 MHz, also drives the FX3 PCLK domain.
reset_  input  1  asynchronous active-low reset.
stream_in_mode_selected  input  1  high while the top level selects Stream IN mode.
flaga_d  input  1  registered FLAGA; 1 = FX3 socket ready to accept data.
flagb_d  input  1  registered FLAGB; 1 = below watermark, 0 = watermark reached.
slwr_streamIN_  output  1  SLWR#, active low.
data_stream_in  output  32  write data to the FX3 data bus.
stream_in_active  output  1  high while a burst is in progress (any state other than idle).
pktend_streamIN_  output  1  PKTEND#, active low; exists only with STREAM_IN_PKTEND_EN.

Behaviour:
- Single clock domain, clk_100. All registers reset asynchronously on reset_ low.
- Reset values: state = idle, slwr_streamIN_ = 1, data_stream_in = DATA_INIT, delay counter = 0, stream_in_active = 0, pktend_streamIN_ = 1.
- The state register is updated on posedge clk_100. The next state is computed combinationally. slwr_streamIN_ and stream_in_active decode directly from the current state, with no extra register stage.
- States (3-bit encoding):
  - idle: moves to flaga_rcvd when stream_in_mode_selected = 1 and flaga_d = 1; otherwise stays in idle.
  - flaga_rcvd: moves to wait_flagb unconditionally after one cycle.
  - wait_flagb: moves to write when flagb_d = 1. Moves to idle when stream_in_mode_selected = 0. Otherwise waits.
  - write: slwr_streamIN_ = 0. Moves to wr_delay when flagb_d = 0 or stream_in_mode_selected = 0. Otherwise stays in write.
  - wr_delay: slwr_streamIN_ = 1. Moves to idle when the delay counter = 0; otherwise decrements the counter.
  - Any illegal encoding moves to idle.
- Delay counter: 3 bits. Loaded with WR_DELAY on every cycle spent in write. In wr_delay, the state lasts exactly WR_DELAY+1 cycles. With WR_DELAY = 0, wr_delay lasts 1 cycle.
- Data pattern:
  - data_stream_in is registered and holds its value whenever slwr_streamIN_ = 1.
  - On each clock edge where the state is write, data_stream_in increments by 1, so consecutive beats carry N, N+1, N+2, ...
  - Wrap-around: 32'hFFFFFFFF → 32'h0, with no flag raised.
  - The pattern continues across bursts; it is not reset per burst.
- Write latency: the first SLWR# low appears 3 cycles after the cycle in which flaga_d = 1 and flagb_d = 1 are both sampled in idle (idle → flaga_rcvd → wait_flagb → write).
- Boundaries:
  - flagb_d falling while in write: the write in that same cycle still happens. The following cycle has SLWR# high. The FX3 watermark must absorb this one beat.
  - Mode deselected in write: same exit path through wr_delay; the burst is never truncated mid-cycle.
  - flaga_d is ignored outside idle.
  - Reset asserted mid-burst: SLWR# goes high immediately (asynchronous) and data returns to DATA_INIT.

Optional Feature:
Macro: STREAM_IN_PKTEND_EN.
- When defined:
  - Adds a 16-bit beat counter that increments on each write beat and resets to 0 on reset_.
  - pktend_streamIN_ = 0 together with SLWR# low on the beat where the counter = PKT_BEATS-1. The counter then returns to 0.
  - On exit from write with a nonzero count, the FX3 short packet is committed: pktend_streamIN_ pulses low for one cycle, with SLWR# high, in the first wr_delay cycle, and the counter clears.
- When undefined: the port and counter are absent, and no packets are committed by the FPGA.

Test Plan:
- Reset, then release with flaga_d = 0 → slwr_streamIN_ = 1, data_stream_in = 0, stream_in_active = 0, state stays idle for 20 cycles.
- Mode = 1, flaga_d = 1, flagb_d = 1 held → SLWR# goes low exactly 3 cycles later; data beats 0, 1, 2, ... each cycle.
- After 10 beats, drop flagb_d → the 11th beat (data 10) is written in the same cycle; SLWR# then stays high for WR_DELAY+1 = 3 cycles; state returns to idle; the next burst starts at data 11.
- Drop stream_in_mode_selected during write → SLWR# high the next cycle; wr_delay for 3 cycles, then idle with no re-entry.
- With DATA_INIT = 32'hFFFFFFFE, run 4 beats → data FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- With STREAM_IN_PKTEND_EN and PKT_BEATS = 4, run a burst of 6 beats → PKTEND# low with beat 3; PKTEND# low alone in the first wr_delay cycle (remainder of 2 beats); beat counter = 0 afterwards.

Source files
------------

// File: rtl/slave_fifo2b_stream_in_if.sv
// slave_fifo2b_stream_in_if: FX3 Slave FIFO Stream IN flags and write strobes/data.
// PKTEND# is present only when STREAM_IN_PKTEND_EN is defined.
interface slave_fifo2b_stream_in_if;
   logic        stream_in_mode_selected;
   logic        flaga_d;
   logic        flagb_d;
   logic        slwr_streamIN_;
   logic [31:0] data_stream_in;
   logic        stream_in_active;
`ifdef STREAM_IN_PKTEND_EN
   logic        pktend_streamIN_;
`endif
   modport master (
      input  stream_in_mode_selected, flaga_d, flagb_d,
      output slwr_streamIN_, data_stream_in, stream_in_active
`ifdef STREAM_IN_PKTEND_EN
      , output pktend_streamIN_
`endif
   );
   modport slave (
      output stream_in_mode_selected, flaga_d, flagb_d,
      input  slwr_streamIN_, data_stream_in, stream_in_active
`ifdef STREAM_IN_PKTEND_EN
      , input pktend_streamIN_
`endif
   );
endinterface

// File: rtl/slave_fifo2b_stream_in.sv
// slave_fifo2b_stream_in: FX3 Slave FIFO Stream IN writer driving an incrementing 32-bit pattern.
// Optional STREAM_IN_PKTEND_EN commits PKT_BEATS-beat and short packets via PKTEND#.
module slave_fifo2b_stream_in #(
   parameter logic [31:0] DATA_INIT = 32'd0,
   parameter int          WR_DELAY  = 2
`ifdef STREAM_IN_PKTEND_EN
   , parameter int        PKT_BEATS = 512
`endif
) (
   input logic clk_100,
   input logic reset_,
   slave_fifo2b_stream_in_if.master bus
);
   typedef enum logic [2:0] {
      idle       = 3'd0,
      flaga_rcvd = 3'd1,
      wait_flagb = 3'd2,
      write      = 3'd3,
      wr_delay   = 3'd4
   } state_t;
   state_t      state, state_n;
   logic [2:0]  dly_cnt;
   logic [31:0] data;
   always_ff @(posedge clk_100 or negedge reset_)
      if (!reset_) state <= idle;
      else state <= state_n;
   always_comb begin
      state_n = idle;
      case (state)
         idle:       state_n = (bus.stream_in_mode_selected && bus.flaga_d) ? flaga_rcvd : idle;
         flaga_rcvd: state_n = wait_flagb;
         wait_flagb: state_n = bus.flagb_d ? write : (bus.stream_in_mode_selected ? wait_flagb : idle);
         write:      state_n = (!bus.flagb_d || !bus.stream_in_mode_selected) ? wr_delay : write;
         wr_delay:   state_n = (dly_cnt == 3'd0) ? idle : wr_delay;
         default:    state_n = idle;
      endcase
   end
   // The beat written in the cycle flagb_d falls is still committed; wr_delay covers FX3 flag latency.
   always_ff @(posedge clk_100 or negedge reset_)
      if (!reset_) begin
         dly_cnt <= 3'd0;
         data    <= DATA_INIT;
      end else if (state == write) begin
         dly_cnt <= 3'(WR_DELAY);
         data    <= data + 32'd1;
      end else if (state == wr_delay && dly_cnt != 3'd0) begin
         dly_cnt <= dly_cnt - 3'd1;
      end
   assign bus.slwr_streamIN_   = (state != write);
   assign bus.stream_in_active = (state != idle);
   assign bus.data_stream_in   = data;
`ifdef STREAM_IN_PKTEND_EN
   logic [15:0] beat_cnt;
   logic        pkt_last;
   assign pkt_last = (beat_cnt == 16'(PKT_BEATS - 1));
   always_ff @(posedge clk_100 or negedge reset_)
      if (!reset_) beat_cnt <= 16'd0;
      else if (state == write) beat_cnt <= pkt_last ? 16'd0 : beat_cnt + 16'd1;
      else if (state == wr_delay) beat_cnt <= 16'd0;
   // A nonzero count in wr_delay can only be seen in its first cycle, so the short-packet pulse is one cycle.
   assign bus.pktend_streamIN_ = !((state == write && pkt_last) || (state == wr_delay && beat_cnt != 16'd0));
`endif
endmodule

// File: tb/tb_slave_fifo2b_stream_in.sv
// tb_slave_fifo2b_stream_in: directed checks of latency, data pattern, exits, wrap and PKTEND#.
module tb_slave_fifo2b_stream_in;
   logic clk_100 = 1'b0;
   logic rst0_, rst1_;
   int   n_cmp = 0, n_bad = 0;
   always #5 clk_100 = ~clk_100;
   slave_fifo2b_stream_in_if if0 ();
   slave_fifo2b_stream_in_if if1 ();
   slave_fifo2b_stream_in #(.DATA_INIT(32'd0), .WR_DELAY(2)) dut0 (
      .clk_100(clk_100), .reset_(rst0_), .bus(if0));
   slave_fifo2b_stream_in #(.DATA_INIT(32'hFFFFFFFE), .WR_DELAY(0)
`ifdef STREAM_IN_PKTEND_EN
      , .PKT_BEATS(4)
`endif
   ) dut1 (.clk_100(clk_100), .reset_(rst1_), .bus(if1));
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk_100);
         #1;
      end
   endtask
   task automatic chk0(string tag, logic slwr, logic [31:0] d, logic act);
      check({tag, ".slwr"}, 32'(if0.slwr_streamIN_), 32'(slwr));
      check({tag, ".data"}, if0.data_stream_in, d);
      check({tag, ".act"}, 32'(if0.stream_in_active), 32'(act));
   endtask
   task automatic chk1(string tag, logic slwr, logic [31:0] d, logic act, logic pk);
      check({tag, ".slwr"}, 32'(if1.slwr_streamIN_), 32'(slwr));
      check({tag, ".data"}, if1.data_stream_in, d);
      check({tag, ".act"}, 32'(if1.stream_in_active), 32'(act));
`ifdef STREAM_IN_PKTEND_EN
      check({tag, ".pktend"}, 32'(if1.pktend_streamIN_), 32'(pk));
`else
      if (pk !== 1'b0 && pk !== 1'b1) check({tag, ".pkarg"}, 32'(pk), 32'd1);
`endif
   endtask
   logic [31:0] wrap_d [6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h2, 32'h3};
   logic        wrap_pk[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
   initial begin
      rst0_ = 1'b0;
      rst1_ = 1'b0;
      if0.stream_in_mode_selected = 1'b0; if0.flaga_d = 1'b0; if0.flagb_d = 1'b0;
      if1.stream_in_mode_selected = 1'b0; if1.flaga_d = 1'b0; if1.flagb_d = 1'b0;
      tick(2);
      chk0("rst", 1'b1, 32'd0, 1'b0);
      chk1("rst1", 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1);
      rst0_ = 1'b1;
      rst1_ = 1'b1;
      if0.stream_in_mode_selected = 1'b1;
      if0.flagb_d = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk0("idle_noflaga", 1'b1, 32'd0, 1'b0);
      end
      // burst 1: latency 3, ten beats, then flagb drop on the eleventh
      if0.flaga_d = 1'b1;
      tick(); chk0("lat1", 1'b1, 32'd0, 1'b1);
      tick(); chk0("lat2", 1'b1, 32'd0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk0("beat", 1'b0, 32'(i), 1'b1);
      end
      tick(); chk0("beat10", 1'b0, 32'd10, 1'b1);
      if0.flagb_d = 1'b0;
      if0.flaga_d = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk0("wrdly", 1'b1, 32'd11, 1'b1);
      end
      tick(); chk0("idle_a", 1'b1, 32'd11, 1'b0);
      tick(); chk0("idle_b", 1'b1, 32'd11, 1'b0);
      // burst 2: mode deselected in write
      if0.flaga_d = 1'b1;
      if0.flagb_d = 1'b1;
      tick(2); chk0("lat_b2", 1'b1, 32'd11, 1'b1);
      tick(); chk0("b2_0", 1'b0, 32'd11, 1'b1);
      if0.flaga_d = 1'b0;
      tick(); chk0("b2_1", 1'b0, 32'd12, 1'b1);
      if0.stream_in_mode_selected = 1'b0;
      if0.flaga_d = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk0("mode_dly", 1'b1, 32'd13, 1'b1);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         chk0("no_reentry", 1'b1, 32'd13, 1'b0);
      end
      // wait_flagb abandoned by mode deselect
      if0.stream_in_mode_selected = 1'b1;
      if0.flagb_d = 1'b0;
      tick(); chk0("wfb_rcvd", 1'b1, 32'd13, 1'b1);
      tick(2); chk0("wfb_wait", 1'b1, 32'd13, 1'b1);
      if0.flaga_d = 1'b0;
      if0.stream_in_mode_selected = 1'b0;
      tick(); chk0("wfb_abort", 1'b1, 32'd13, 1'b0);
      // dut1: wrap-around, WR_DELAY=0, packet end with remainder
      if1.stream_in_mode_selected = 1'b1;
      if1.flaga_d = 1'b1;
      if1.flagb_d = 1'b1;
      tick(2); chk1("w_lat", 1'b1, 32'hFFFFFFFE, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk1("wrap", 1'b0, wrap_d[i], 1'b1, wrap_pk[i]);
      end
      if1.flagb_d = 1'b0;
      if1.flaga_d = 1'b0;
      tick(); chk1("short_pkt", 1'b1, 32'd4, 1'b1, 1'b0);
      tick(); chk1("w_idle", 1'b1, 32'd4, 1'b0, 1'b1);
      // exactly one full packet: counter restarted at 0, no short packet after it
      if1.flaga_d = 1'b1;
      if1.flagb_d = 1'b1;
      tick(2);
      if1.flaga_d = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk1("pkt2", 1'b0, 32'(4 + i), 1'b1, i != 3);
      end
      if1.flagb_d = 1'b0;
      tick(); chk1("pkt2_dly", 1'b1, 32'd8, 1'b1, 1'b1);
      tick(); chk1("pkt2_idle", 1'b1, 32'd8, 1'b0, 1'b1);
      // asynchronous reset mid-burst on dut0
      if0.stream_in_mode_selected = 1'b1;
      if0.flaga_d = 1'b1;
      if0.flagb_d = 1'b1;
      tick(3); chk0("b3_0", 1'b0, 32'd13, 1'b1);
      tick(); chk0("b3_1", 1'b0, 32'd14, 1'b1);
      #2 rst0_ = 1'b0;
      #1 chk0("async_rst", 1'b1, 32'd0, 1'b0);
      tick(); rst0_ = 1'b1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
